// File: rtl/display_scan_if.sv
// Bundle between a host and display_scan_controller.
//   Host -> controller: enable, value_in[15:0], dp_in[3:0], update, lz_blank
//   Controller -> host: digit_count[1:0], nibble[3:0], dp, seg_en, frame_done
// Handshake: update is a fire-and-forget strobe with no ready. Every cycle
// with update=1 is accepted unconditionally; value_in/dp_in are sampled in
// that same cycle, and a later strobe overwrites an earlier one that has not
// yet reached the display.
interface display_scan_if;
  logic        enable;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        update;
  logic        lz_blank;
  logic [1:0]  digit_count;
  logic [3:0]  nibble;
  logic        dp;
  logic        seg_en;
  logic        frame_done;

  modport master (
    output enable, value_in, dp_in, update, lz_blank,
    input  digit_count, nibble, dp, seg_en, frame_done
  );

  modport slave (
    input  enable, value_in, dp_in, update, lz_blank,
    output digit_count, nibble, dp, seg_en, frame_done
  );
endinterface

// File: rtl/display_scan_controller.sv
// Time-multiplexes a 16-bit hex value onto a 4-digit 7-segment display.
// Each digit gets BLANK_CYCLES of dark guard time followed by DWELL_CYCLES of
// lit time. New values are staged on update and moved into the shadow
// (displayed) register only at frame start, so a frame is never torn.
// Ports:
//   clk        system clock
//   reset_n    asynchronous reset, active low
//   bus        display_scan_if.slave (inputs: enable, value_in, dp_in,
//              update, lz_blank; outputs: digit_count, nibble, dp, seg_en,
//              frame_done)
//   state_dbg  current FSM state (IDLE=0, BLANK=1, DRIVE=2)
module display_scan_controller #(
  parameter int DWELL_CYCLES = 2000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic               clk,
  input  logic               reset_n,
  display_scan_if.slave      bus,
  output logic [1:0]         state_dbg
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   staging;
  logic [3:0]    staging_dp;
  logic          pending;
  logic [15:0]   shadow;
  logic [3:0]    shadow_dp;
  logic [1:0]    digit_count;
  logic [3:0]    nibble;
  logic          dp;
  logic          seg_en;
  logic          frame_done;

  // Digit 0 is the MSB nibble / dp bit 3.
  function automatic logic [3:0] pick_nibble(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  function automatic logic pick_dp(input logic [3:0] d, input logic [1:0] k);
    case (k)
      2'd0:    return d[3];
      2'd1:    return d[2];
      2'd2:    return d[1];
      default: return d[0];
    endcase
  endfunction

  logic        blank_done;
  logic        dwell_done;
  logic        frame_end;
  logic        load_frame;
  logic [15:0] shadow_nx;
  logic [3:0]  shadow_dp_nx;
  logic        z0, z1, z2;
  logic        suppress;
  logic [1:0]  next_digit;

  assign blank_done = (cnt == BLANK_LAST);
  assign dwell_done = (cnt == DWELL_LAST);
  assign frame_end  = (state == DRIVE) && dwell_done && (digit_count == 2'd3);
  assign next_digit = digit_count + 2'd1;

  // Every entry to BLANK at digit 0: either leaving IDLE or wrapping from
  // digit 3. The shadow takes the staging contents as they were before this
  // edge, so a same-cycle update stays pending for the following frame.
  assign load_frame   = bus.enable && ((state == IDLE) || frame_end);
  assign shadow_nx    = (load_frame && pending) ? staging    : shadow;
  assign shadow_dp_nx = (load_frame && pending) ? staging_dp : shadow_dp;

  // Running "all leading digits zero" chain over the shadow value.
  assign z0 = (shadow[15:12] == 4'h0);
  assign z1 = z0 && (shadow[11:8] == 4'h0);
  assign z2 = z1 && (shadow[7:4] == 4'h0);

  always_comb begin
    suppress = 1'b0;
    case (digit_count)
      2'd0:    suppress = bus.lz_blank && z0;
      2'd1:    suppress = bus.lz_blank && z1;
      2'd2:    suppress = bus.lz_blank && z2;
      default: suppress = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      staging     <= '0;
      staging_dp  <= '0;
      pending     <= 1'b0;
      shadow      <= '0;
      shadow_dp   <= '0;
      digit_count <= '0;
      nibble      <= '0;
      dp          <= 1'b0;
      seg_en      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      shadow     <= shadow_nx;
      shadow_dp  <= shadow_dp_nx;

      if (bus.update) begin
        staging    <= bus.value_in;
        staging_dp <= bus.dp_in;
        pending    <= 1'b1;
      end else if (load_frame) begin
        pending <= 1'b0;
      end

      if (!bus.enable) begin
        state       <= IDLE;
        cnt         <= '0;
        digit_count <= '0;
        nibble      <= '0;
        dp          <= 1'b0;
        seg_en      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state       <= BLANK;
            cnt         <= '0;
            digit_count <= 2'd0;
            nibble      <= pick_nibble(shadow_nx, 2'd0);
            seg_en      <= 1'b0;
            dp          <= 1'b0;
          end
          BLANK: begin
            if (blank_done) begin
              // lz_blank is sampled here and the decision holds for the dwell.
              state  <= DRIVE;
              cnt    <= '0;
              seg_en <= !suppress;
              dp     <= !suppress && pick_dp(shadow_dp, digit_count);
            end else begin
              cnt    <= cnt + CW'(1);
              seg_en <= 1'b0;
              dp     <= 1'b0;
            end
          end
          DRIVE: begin
            if (dwell_done) begin
              // Index and nibble move only while dark so the translator
              // settles before segments light again.
              state       <= BLANK;
              cnt         <= '0;
              digit_count <= next_digit;
              nibble      <= pick_nibble(shadow_nx, next_digit);
              seg_en      <= 1'b0;
              dp          <= 1'b0;
              frame_done  <= (digit_count == 2'd3);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state  <= IDLE;
            seg_en <= 1'b0;
            dp     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.digit_count = digit_count;
  assign bus.nibble      = nibble;
  assign bus.dp          = dp;
  assign bus.seg_en      = seg_en;
  assign bus.frame_done  = frame_done;
  assign state_dbg       = state;

endmodule
